// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the multi-buffered frame store.
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VSYNC = 2'd1,
        CLEAR      = 2'd2
    } fb_state_t;

    typedef logic [1:0] bank_idx_t;

    localparam bank_idx_t NO_BANK = 2'd3;

    function automatic int addr_bits(input int width, input int height);
        int pixels;
        pixels = width * height;
        return (pixels > 1) ? $clog2(pixels) : 1;
    endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// Renderer, display and status signals of the frame store, grouped as one bus.
interface frame_buffer_if #(
    parameter int ADDR_BITS  = 19,
    parameter int PIXEL_BITS = 1
);
    logic                  wr_en;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [PIXEL_BITS-1:0] wr_data;
    logic                  wr_ready;
    logic                  swap_req;
    logic                  swap_ack;
    logic                  clear_en;
    logic                  frame_start;
    logic                  rd_en;
    logic [ADDR_BITS-1:0]  rd_addr;
    logic [PIXEL_BITS-1:0] rd_data;
    logic                  rd_valid;
    logic [1:0]            front_idx;
    logic [7:0]            dropped_frames;

    modport slave (
        input  wr_en, wr_addr, wr_data, swap_req, clear_en, frame_start, rd_en, rd_addr,
        output wr_ready, swap_ack, rd_data, rd_valid, front_idx, dropped_frames
    );

    modport master (
        output wr_en, wr_addr, wr_data, swap_req, clear_en, frame_start, rd_en, rd_addr,
        input  wr_ready, swap_ack, rd_data, rd_valid, front_idx, dropped_frames
    );
endinterface

// File: rtl/frame_buffer_bank.sv
// One frame bank: single write port, registered read port, both gated by ce.
module frame_buffer_bank #(
    parameter int DEPTH      = 307200,
    parameter int PIXEL_BITS = 1,
    parameter int ADDR_BITS  = 19
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic                  we_i,
    input  logic [ADDR_BITS-1:0]  waddr_i,
    input  logic [PIXEL_BITS-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_BITS-1:0]  raddr_i,
    output logic [PIXEL_BITS-1:0] rdata_o
);
    localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIXEL_BITS-1:0] mem_q [DEPTH];
    logic [PIXEL_BITS-1:0] rdata_q;

    // Callers only assert we_i/re_i for in-range addresses.
    always_ff @(posedge clk) begin
        if (ce && we_i) begin
            mem_q[waddr_i[IDX_BITS-1:0]] <= wdata_i;
        end
        if (ce && re_i) begin
            rdata_q <= mem_q[raddr_i[IDX_BITS-1:0]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_multi.sv
// Double/triple-buffered frame store with vsync-aligned promotion and optional hardware clear.
module frame_buffer_multi
    import frame_buffer_pkg::*;
#(
    parameter int                    FB_WIDTH    = 640,
    parameter int                    FB_HEIGHT   = 480,
    parameter int                    PIXEL_BITS  = 1,
    parameter int                    BUFFERS     = 2,
    parameter logic [PIXEL_BITS-1:0] CLEAR_VALUE = {PIXEL_BITS{1'b0}},
    parameter int                    ADDR_BITS   = addr_bits(FB_WIDTH, FB_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    frame_buffer_if.slave bus
);
    localparam int                   DEPTH     = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_BITS-1:0] LAST_PIX  = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS:0]   DEPTH_EXT = (ADDR_BITS + 1)'(DEPTH);

    if ((BUFFERS != 2) && (BUFFERS != 3)) begin : g_bad_buffers
        $error("frame_buffer_multi: BUFFERS must be 2 or 3");
    end

    fb_state_t            state_q, state_d;
    bank_idx_t            front_q, front_d, back_q, back_d, spare_q, spare_d, pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 clr_req_q, clr_req_d;
    logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic                 swap_ack_q, swap_ack_d;
    logic [7:0]           dropped_q, dropped_d;
    logic                 rd_valid_q, rd_oob_q;
    bank_idx_t            rd_sel_q;

    logic                  wr_ready_s, accept_s, promote_s, wr_sel_s;
    logic                  wr_in_range_s, rd_in_range_s;
    logic [ADDR_BITS-1:0]  wr_addr_s;
    logic [PIXEL_BITS-1:0] wr_data_s, rd_mux_s;
    logic [PIXEL_BITS-1:0] bank_rdata_s [BUFFERS];

    assign wr_ready_s    = (state_q == IDLE);
    assign accept_s      = bus.swap_req && wr_ready_s;
    assign promote_s     = bus.frame_start && pend_valid_q && (BUFFERS == 3);
    assign wr_in_range_s = ({1'b0, bus.wr_addr} < DEPTH_EXT);
    assign rd_in_range_s = ({1'b0, bus.rd_addr} < DEPTH_EXT);

    // Next-state: triple-mode promotion is applied before acceptance so both can share a cycle.
    always_comb begin
        state_d      = state_q;
        front_d      = front_q;
        back_d       = back_q;
        spare_d      = spare_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        clr_req_d    = clr_req_q;
        clr_cnt_d    = clr_cnt_q;
        swap_ack_d   = 1'b0;
        dropped_d    = dropped_q;

        if (promote_s) begin
            front_d      = pend_q;
            spare_d      = front_q;
            pend_valid_d = 1'b0;
        end else begin
            front_d = front_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s && (BUFFERS == 3)) begin
                    if (pend_valid_d) begin
                        back_d    = pend_q;
                        dropped_d = (dropped_q == 8'hFF) ? dropped_q : dropped_q + 8'd1;
                    end else begin
                        back_d  = spare_d;
                        spare_d = NO_BANK;
                    end
                    pend_d       = back_q;
                    pend_valid_d = 1'b1;
                    clr_cnt_d    = {ADDR_BITS{1'b0}};
                    state_d      = bus.clear_en ? CLEAR : IDLE;
                    swap_ack_d   = !bus.clear_en;
                end else if (accept_s) begin
                    pend_d       = back_q;
                    pend_valid_d = 1'b1;
                    clr_req_d    = bus.clear_en;
                    state_d      = WAIT_VSYNC;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_VSYNC: begin
                if (bus.frame_start) begin
                    front_d      = pend_q;
                    back_d       = front_q;
                    pend_valid_d = 1'b0;
                    clr_cnt_d    = {ADDR_BITS{1'b0}};
                    state_d      = clr_req_q ? CLEAR : IDLE;
                    swap_ack_d   = !clr_req_q;
                end else begin
                    state_d = WAIT_VSYNC;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == LAST_PIX) begin
                    state_d    = IDLE;
                    swap_ack_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bookkeeping registers; everything holds while ce is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            front_q      <= 2'd0;
            back_q       <= 2'd1;
            spare_q      <= (BUFFERS == 3) ? 2'd2 : NO_BANK;
            pend_q       <= NO_BANK;
            pend_valid_q <= 1'b0;
            clr_req_q    <= 1'b0;
            clr_cnt_q    <= {ADDR_BITS{1'b0}};
            swap_ack_q   <= 1'b0;
            dropped_q    <= 8'd0;
        end else if (ce) begin
            state_q      <= state_d;
            front_q      <= front_d;
            back_q       <= back_d;
            spare_q      <= spare_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            clr_req_q    <= clr_req_d;
            clr_cnt_q    <= clr_cnt_d;
            swap_ack_q   <= swap_ack_d;
            dropped_q    <= dropped_d;
        end
    end

    // Read tracking; the bank is latched from front_q before any same-cycle promotion.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 2'd0;
            rd_oob_q   <= 1'b1;
        end else if (ce) begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_sel_q <= front_q;
                rd_oob_q <= !rd_in_range_s;
            end
        end
    end

    assign wr_sel_s  = (state_q == CLEAR) || (bus.wr_en && wr_ready_s && wr_in_range_s);
    assign wr_addr_s = (state_q == CLEAR) ? clr_cnt_q : bus.wr_addr;
    assign wr_data_s = (state_q == CLEAR) ? CLEAR_VALUE : bus.wr_data;

    for (genvar i = 0; i < BUFFERS; i++) begin : g_bank
        frame_buffer_bank #(
            .DEPTH      (DEPTH),
            .PIXEL_BITS (PIXEL_BITS),
            .ADDR_BITS  (ADDR_BITS)
        ) u_bank (
            .clk     (clk),
            .ce      (ce),
            .we_i    (wr_sel_s && (back_q == bank_idx_t'(i))),
            .waddr_i (wr_addr_s),
            .wdata_i (wr_data_s),
            .re_i    (bus.rd_en && rd_in_range_s && (front_q == bank_idx_t'(i))),
            .raddr_i (bus.rd_addr),
            .rdata_o (bank_rdata_s[i])
        );
    end

    // Select the bank captured at read time.
    always_comb begin
        rd_mux_s = CLEAR_VALUE;
        for (int i = 0; i < BUFFERS; i++) begin
            rd_mux_s = (rd_sel_q == bank_idx_t'(i)) ? bank_rdata_s[i] : rd_mux_s;
        end
    end

    assign bus.rd_data        = rd_oob_q ? CLEAR_VALUE : rd_mux_s;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.wr_ready       = wr_ready_s;
    assign bus.swap_ack       = swap_ack_q;
    assign bus.front_idx      = front_q;
    assign bus.dropped_frames = dropped_q;

endmodule

// File: tb/tb_frame_buffer_multi.sv
// Directed bench: double-buffered and triple-buffered 8x4 instances with hand-computed expectations.
module tb_frame_buffer_multi;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    frame_buffer_if #(.ADDR_BITS(6), .PIXEL_BITS(1)) b2();
    frame_buffer_if #(.ADDR_BITS(6), .PIXEL_BITS(1)) b3();

    frame_buffer_multi #(
        .FB_WIDTH(8), .FB_HEIGHT(4), .PIXEL_BITS(1), .BUFFERS(2), .CLEAR_VALUE(1'b0), .ADDR_BITS(6)
    ) dut2 (.clk(clk), .rst(rst), .ce(ce), .bus(b2.slave));

    frame_buffer_multi #(
        .FB_WIDTH(8), .FB_HEIGHT(4), .PIXEL_BITS(1), .BUFFERS(3), .CLEAR_VALUE(1'b0), .ADDR_BITS(6)
    ) dut3 (.clk(clk), .rst(rst), .ce(ce), .bus(b3.slave));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic mon3   = 1'b0;
    logic wr3_low = 1'b0;

    // Watch triple-mode wr_ready while the renderer is running ahead.
    always @(negedge clk) begin
        if (mon3 && !b3.wr_ready) wr3_low = 1'b1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_pix(input int sel, input int addr, input logic d);
        if (sel == 2) begin
            b2.wr_en = 1'b1; b2.wr_addr = 6'(addr); b2.wr_data = d;
        end else begin
            b3.wr_en = 1'b1; b3.wr_addr = 6'(addr); b3.wr_data = d;
        end
        cyc(1);
        b2.wr_en = 1'b0;
        b3.wr_en = 1'b0;
    endtask

    task automatic pulse(input int sel, input logic swap, input logic clr, input logic fs);
        if (sel == 2) begin
            b2.swap_req = swap; b2.clear_en = clr; b2.frame_start = fs;
        end else begin
            b3.swap_req = swap; b3.clear_en = clr; b3.frame_start = fs;
        end
        cyc(1);
        b2.swap_req = 1'b0; b2.clear_en = 1'b0; b2.frame_start = 1'b0;
        b3.swap_req = 1'b0; b3.clear_en = 1'b0; b3.frame_start = 1'b0;
    endtask

    task automatic read_chk(input int sel, input int addr, input logic exp, input string tag);
        if (sel == 2) begin
            b2.rd_en = 1'b1; b2.rd_addr = 6'(addr);
        end else begin
            b3.rd_en = 1'b1; b3.rd_addr = 6'(addr);
        end
        cyc(1);
        b2.rd_en = 1'b0;
        b3.rd_en = 1'b0;
        chk_eq({tag, "_valid"}, (sel == 2) ? b2.rd_valid : b3.rd_valid, 1);
        chk_eq({tag, "_data"},  (sel == 2) ? b2.rd_data  : b3.rd_data,  exp);
    endtask

    initial begin
        int   n;
        logic ok;
        logic ack_seen;

        rst = 1'b1;
        ce  = 1'b1;
        b2.wr_en = 1'b0; b2.wr_addr = 6'd0; b2.wr_data = 1'b0; b2.swap_req = 1'b0;
        b2.clear_en = 1'b0; b2.frame_start = 1'b0; b2.rd_en = 1'b0; b2.rd_addr = 6'd0;
        b3.wr_en = 1'b0; b3.wr_addr = 6'd0; b3.wr_data = 1'b0; b3.swap_req = 1'b0;
        b3.clear_en = 1'b0; b3.frame_start = 1'b0; b3.rd_en = 1'b0; b3.rd_addr = 6'd0;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        chk_eq("rst_front",    b2.front_idx, 0);
        chk_eq("rst_wr_ready", b2.wr_ready, 1);
        chk_eq("rst_swap_ack", b2.swap_ack, 0);
        chk_eq("rst_rd_valid", b2.rd_valid, 0);
        chk_eq("rst_rd_data",  b2.rd_data, 0);
        chk_eq("rst_dropped",  b2.dropped_frames, 0);
        chk_eq("rst3_front",   b3.front_idx, 0);
        chk_eq("rst3_ready",   b3.wr_ready, 1);

        // Double buffering: swap waits for frame_start.
        for (int a = 0; a < 16; a++) wr_pix(2, a, 1'b1);
        pulse(2, 1'b1, 1'b0, 1'b0);
        chk_eq("t1_wait_ready", b2.wr_ready, 0);
        ack_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (b2.swap_ack) ack_seen = 1'b1;
            cyc(1);
        end
        chk_eq("t1_no_early_ack", ack_seen, 0);
        pulse(2, 1'b0, 1'b0, 1'b1);
        chk_eq("t1_ack",   b2.swap_ack, 1);
        chk_eq("t1_front", b2.front_idx, 1);
        chk_eq("t1_ready", b2.wr_ready, 1);
        cyc(1);
        chk_eq("t1_ack_pulse", b2.swap_ack, 0);
        for (int a = 0; a < 16; a++) read_chk(2, a, 1'b1, "t1_rd");
        cyc(1);
        chk_eq("t1_rd_valid_low", b2.rd_valid, 0);

        // Double buffering with hardware clear of the reacquired bank.
        for (int a = 0; a < 32; a++) wr_pix(2, a, 1'b1);
        pulse(2, 1'b1, 1'b1, 1'b0);
        pulse(2, 1'b0, 1'b0, 1'b1);
        n = 0; ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (b2.swap_ack) begin ok = 1'b1; break; end
            if (!b2.wr_ready) n++;
            cyc(1);
        end
        chk_eq("t2_ack_seen",    ok, 1);
        chk_eq("t2_clear_cycles", n, 32);
        chk_eq("t2_ready_at_ack", b2.wr_ready, 1);
        chk_eq("t2_front", b2.front_idx, 0);
        read_chk(2, 5, 1'b1, "t2_front_rd");
        pulse(2, 1'b1, 1'b0, 1'b0);
        pulse(2, 1'b0, 1'b0, 1'b1);
        chk_eq("t2_front2", b2.front_idx, 1);
        for (int a = 0; a < 32; a++) read_chk(2, a, 1'b0, "t2_cleared");

        // Out-of-range write and read.
        wr_pix(2, 32, 1'b0);
        pulse(2, 1'b1, 1'b0, 1'b0);
        pulse(2, 1'b0, 1'b0, 1'b1);
        chk_eq("t5_front", b2.front_idx, 0);
        read_chk(2, 0, 1'b1, "t5_addr0");
        read_chk(2, 32, 1'b0, "t5_oob_rd");
        read_chk(2, 31, 1'b1, "t5_addr31");

        // Triple buffering: latest frame wins.
        mon3 = 1'b1;
        for (int a = 0; a < 32; a++) wr_pix(3, a, 1'b1);
        pulse(3, 1'b1, 1'b0, 1'b0);
        chk_eq("t3_ack1", b3.swap_ack, 1);
        for (int a = 0; a < 32; a++) wr_pix(3, a, 1'b0);
        pulse(3, 1'b1, 1'b0, 1'b0);
        chk_eq("t3_ack2",    b3.swap_ack, 1);
        chk_eq("t3_dropped", b3.dropped_frames, 1);
        mon3 = 1'b0;
        chk_eq("t3_never_low", wr3_low, 0);
        pulse(3, 1'b0, 1'b0, 1'b1);
        chk_eq("t3_front", b3.front_idx, 2);
        read_chk(3, 3, 1'b0, "t3_frameB_3");
        read_chk(3, 20, 1'b0, "t3_frameB_20");

        // Same-cycle frame_start and swap with a frame pending.
        wr_pix(3, 0, 1'b1);
        pulse(3, 1'b1, 1'b0, 1'b0);
        wr_pix(3, 0, 1'b0);
        pulse(3, 1'b1, 1'b0, 1'b1);
        chk_eq("t4_front",   b3.front_idx, 1);
        chk_eq("t4_dropped", b3.dropped_frames, 1);
        chk_eq("t4_ack",     b3.swap_ack, 1);
        read_chk(3, 0, 1'b1, "t4_old_pend");
        pulse(3, 1'b0, 1'b0, 1'b1);
        chk_eq("t4_front_pend", b3.front_idx, 0);
        read_chk(3, 0, 1'b0, "t4_old_back");
        wr_pix(3, 7, 1'b1);
        pulse(3, 1'b1, 1'b0, 1'b0);
        pulse(3, 1'b0, 1'b0, 1'b1);
        chk_eq("t4_front_back", b3.front_idx, 2);
        read_chk(3, 7, 1'b1, "t4_new_back_7");
        read_chk(3, 6, 1'b0, "t4_new_back_6");

        // Reset in the middle of a clear.
        pulse(2, 1'b1, 1'b1, 1'b0);
        pulse(2, 1'b0, 1'b0, 1'b1);
        cyc(5);
        chk_eq("t6_in_clear", b2.wr_ready, 0);
        rst = 1'b1;
        cyc(1);
        chk_eq("t6_front", b2.front_idx, 0);
        chk_eq("t6_ready", b2.wr_ready, 1);
        chk_eq("t6_ack",   b2.swap_ack, 0);
        rst = 1'b0;
        cyc(1);

        // Clock enable held low for 10 cycles during a clear.
        pulse(2, 1'b1, 1'b1, 1'b0);
        pulse(2, 1'b0, 1'b0, 1'b1);
        n = 0; ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (b2.swap_ack) begin ok = 1'b1; break; end
            if (k == 5)  ce = 1'b0;
            if (k == 15) ce = 1'b1;
            n++;
            cyc(1);
        end
        ce = 1'b1;
        chk_eq("t7_ack_seen", ok, 1);
        chk_eq("t7_cycles",   n, 42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
